// File: rtl/alu_seq.sv
// Registered, handshaked ALU with persistent carry flag, multi-cycle shifts and
// an optional iterative shift-add multiplier (enabled by ALU_SEQ_MUL_EN).
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_OR  = 4'b0010,
                         OP_AND = 4'b0011, OP_XOR = 4'b0100, OP_NOT = 4'b0101,
                         OP_SHL = 4'b0110, OP_SHR = 4'b0111, OP_ADC = 4'b1000,
                         OP_SBC = 4'b1001;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1010;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Handshake: a transfer happens on an edge where valid && ready; in_ready is
  // high only in IDLE, out_valid only in DONE, so accept and retire never overlap.
  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt;
  logic             cflag;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] a_q, hi_q;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] nhi;
`endif

  logic [SHW-1:0]   n;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] s_y, nlo, fin_y;
  logic             s_c, s_ov, b_c, fin_en, fin_c, fin_ov, is_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign n         = b[SHW-1:0];
  assign is_shift  = (op == OP_SHL) || (op == OP_SHR);

  // Single-cycle results, computed straight from the inputs at the accept edge.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cflag};
    dif  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) & cflag};
    s_y  = '0;
    s_c  = 1'b0;
    s_ov = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        s_y  = sum[WIDTH-1:0];
        s_c  = sum[WIDTH];
        s_ov = (a[WIDTH-1] == b[WIDTH-1]) && (s_y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        s_y  = dif[WIDTH-1:0];
        s_c  = dif[WIDTH];
        s_ov = (a[WIDTH-1] != b[WIDTH-1]) && (s_y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:          s_y = a | b;
      OP_AND:         s_y = a & b;
      OP_XOR:         s_y = a ^ b;
      OP_NOT:         s_y = ~a;
      OP_SHL, OP_SHR: s_y = a;
      default:        s_y = '0;
    endcase
  end

  // One BUSY step: a 1-bit shift, or one shift-add round of the multiplier.
  always_comb begin
    nlo = lo_q;
    b_c = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    nhi  = hi_q;
`endif
    case (op_q)
      OP_SHL: begin
        nlo = {lo_q[WIDTH-2:0], 1'b0};
        b_c = lo_q[WIDTH-1];
      end
      OP_SHR: begin
        nlo = {1'b0, lo_q[WIDTH-1:1]};
        b_c = lo_q[0];
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        nhi = msum[WIDTH:1];
        nlo = {msum[0], lo_q[WIDTH-1:1]};
        b_c = (msum[WIDTH:1] != '0);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    fin_en = 1'b0;
    fin_y  = s_y;
    fin_c  = s_c;
    fin_ov = s_ov;
    if (state == IDLE && in_valid) begin
      fin_en = !(is_shift && n != '0);
`ifdef ALU_SEQ_MUL_EN
      if (op == OP_MUL) fin_en = 1'b0;
`endif
    end else if (state == BUSY && cnt == CW'(1)) begin
      fin_en = 1'b1;
      fin_y  = nlo;
      fin_c  = b_c;
      fin_ov = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      fin_ov = (op_q == OP_MUL) && b_c;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      lo_q     <= '0;
      cnt      <= '0;
      cflag    <= 1'b0;
      y        <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      a_q      <= '0;
      hi_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op;
          lo_q <= a;
          cnt  <= CW'(n);
          if (is_shift && n != '0) state <= BUSY;
`ifdef ALU_SEQ_MUL_EN
          if (op == OP_MUL) begin
            a_q   <= a;
            lo_q  <= b;
            hi_q  <= '0;
            cnt   <= CW'(WIDTH);
            state <= BUSY;
          end
`endif
        end
        BUSY: begin
          lo_q <= nlo;
          cnt  <= cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
          hi_q <= nhi;
`endif
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fin_en) begin
        state    <= DONE;
        y        <= fin_y;
        zero     <= (fin_y == '0);
        negative <= fin_y[WIDTH-1];
        carry    <= fin_c;
        overflow <= fin_ov;
        cflag    <= fin_c;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq checked against an integer-arithmetic
// reference model; honours ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;
  localparam int W   = 8;
  localparam int SHW = $clog2(W);
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         zero, carry, overflow, negative;

  int vectors = 0;
  int misses  = 0;
  int model_cf = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .carry(carry), .overflow(overflow), .negative(negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      misses++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Returns {ov, c, y} from plain integer arithmetic.
  function automatic int ref_op(input int o, input int x, input int z, input int cf);
    int r, s, n, c, ov, ci;
    n = z & ((1 << SHW) - 1);
    r = 0; c = 0; ov = 0;
    case (o)
      0, 8: begin
        ci = (o == 8) ? cf : 0;
        r  = x + z + ci;
        c  = (r > MASK);
        s  = sgn(x) + sgn(z) + ci;
        ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      end
      1, 9: begin
        ci = (o == 9) ? cf : 0;
        r  = x - z - ci;
        c  = (r < 0);
        s  = sgn(x) - sgn(z) - ci;
        ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      end
      2: r = x | z;
      3: r = x & z;
      4: r = x ^ z;
      5: r = ~x;
      6: begin r = x << n; c = (n > 0) ? (x >> (W - n)) & 1 : 0; end
      7: begin r = x >> n; c = (n > 0) ? (x >> (n - 1)) & 1 : 0; end
`ifdef ALU_SEQ_MUL_EN
      10: begin r = x * z; c = ((r >> W) != 0); ov = c; end
`endif
      default: r = 0;
    endcase
    return (ov << (W + 1)) | (c << W) | (r & MASK);
  endfunction

  function automatic int ref_lat(input int o, input int z);
    int n;
    n = z & ((1 << SHW) - 1);
    if ((o == 6 || o == 7) && n > 0) return n + 1;
`ifdef ALU_SEQ_MUL_EN
    if (o == 10) return W + 1;
`endif
    return 1;
  endfunction

  task automatic accept(input int o, input int x, input int z);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; op = 4'(o); a = W'(x); b = W'(z);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 4'($urandom);
  endtask

  // Apply one op, check latency/result/flags, optionally stall the consumer.
  task automatic run_op(input int o, input int x, input int z, input int hold);
    int exp, ey, lat;
    logic [W-1:0] y0;
    exp = ref_op(o, x, z, model_cf);
    ey  = exp & MASK;
    accept(o, x, z);
    lat = 1;
    while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk($sformatf("lat op%0d", o), lat, ref_lat(o, z));
    chk($sformatf("y op%0d a%0h b%0h", o, x, z), int'(y), ey);
    chk("carry", int'(carry), (exp >> W) & 1);
    chk("overflow", int'(overflow), (exp >> (W + 1)) & 1);
    chk("zero", int'(zero), int'(ey == 0));
    chk("negative", int'(negative), (ey >> (W - 1)) & 1);
    model_cf = (exp >> W) & 1;
    y0 = y;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_y", int'(y), int'(y0));
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("retire_idle", int'(in_ready), 1);
    chk("retire_valid", int'(out_valid), 0);
  endtask

  initial begin
    int o;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_flags", int'({zero, carry, overflow, negative}), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 'h7F, 'h01, 0);
    run_op(1, 'h00, 'h01, 0);
    run_op(9, 'h05, 'h02, 0);
    run_op(6, 'h81, 3, 0);
    run_op(7, 'h81, 1, 0);
    run_op(6, 'h5A, 0, 0);
    run_op(10, 'h0F, 'h11, 0);
    run_op(10, 'h10, 'h10, 0);
    run_op(0, 'h33, 'h44, 5);

    for (int i = 0; i < 200; i++) begin
      o = $urandom_range(0, 15);
      run_op(o, $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 2));
    end

    // Abort a long op with reset while cflag is set.
    run_op(1, 'h00, 'h01, 0);
`ifdef ALU_SEQ_MUL_EN
    accept(10, 'h0F, 'h11);
`else
    accept(6, 'h81, 7);
`endif
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_y", int'(y), 0);
    chk("midrst_flags", int'({zero, carry, overflow, negative}), 0);
    model_cf = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_op(8, 'h01, 'h01, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Arbitrary datapath width, valid/ready handshakes on both sides, and a persistent carry flag for ADC/SBC chaining.
- Multi-cycle variable shifts and an iterative multiplier.
- Sits between the operand/opcode source (register file or sequencer) and the writeback stage.

Parameters:
- WIDTH, 8, operand/result width in bits, >= 2.
- SHW, $clog2(WIDTH), width of shift-amount field taken from b[SHW-1:0].

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B, or shift amount in b[SHW-1:0]
- op  input  4  opcode
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- zero  output  1  y == 0
- carry  output  1  carry/borrow/shift-out/mul-high-nonzero
- overflow  output  1  signed overflow
- negative  output  1  y[WIDTH-1]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - y=0, zero=0, carry=0, overflow=0, negative=0.
  - Internal carry flag (cflag)=0.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE: accept when in_valid=1; capture a, b, op.
  - Single-cycle ops, or shift with amount 0: go to DONE next edge (latency 1).
  - Shifts with amount n>0: go to BUSY.
  - MUL: go to BUSY.
- Opcodes. All arithmetic is modulo 2^WIDTH. Each op sets carry (c) and overflow (ov) as listed.
  - 0000 ADD y=a+b; c=carry-out; ov=signed add overflow.
  - 0001 SUB y=a-b; c=borrow (1 when a<b unsigned); ov=signed sub overflow.
  - 0010 OR; c=0, ov=0.
  - 0011 AND; c=0, ov=0.
  - 0100 XOR; c=0, ov=0.
  - 0101 NOT y=~a; c=0, ov=0.
  - 0110 SHL by n: one bit per BUSY cycle; c=last bit shifted out (0 if n=0); ov=0.
  - 0111 SHR logical by n: one bit per BUSY cycle; c=last bit shifted out; ov=0.
  - 1000 ADC y=a+b+cflag; c and ov as ADD.
  - 1001 SBC y=a-b-cflag; c=borrow, ov as SUB.
  - 1010 MUL: low WIDTH bits of a*b, shift-add, WIDTH BUSY cycles (latency WIDTH+1); c=ov=(high half !=0).
  - 1011-1111: y=0, c=0, ov=0, latency 1.
- Latency: shift latency is n+1. BUSY decrements an internal count and moves to DONE when it expires.
- DONE:
  - y and all flags held stable while out_ready=0.
  - On out_valid&&out_ready, return to IDLE. No new accept in the same cycle; peak throughput is one op per 2 cycles.
- cflag updates: loaded from c only when an operation reaches DONE. cflag is also loaded on logic/undefined ops (to 0).
- zero and negative are always derived from the final y.
- Reset mid-operation (BUSY or DONE) aborts the operation: reset values, no partial result, cflag cleared.
- in_valid while not IDLE is ignored; the source must hold it until accepted.
- a, b, op are sampled only at the accept edge; later changes have no effect.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 1010 is the iterative multiplier described above.
- Undefined: the multiplier datapath is absent, and 1010 behaves like 1011-1111 (y=0, zero=1, c=0, ov=0, latency 1).

Test Plan:
- ADD: WIDTH=8, a=0x7F, b=0x01 -> one cycle after accept: y=0x80, negative=1, overflow=1, carry=0, zero=0.
- SUB then SBC chain: SUB 0x00-0x01 -> y=0xFF, carry=1; then SBC a=0x05, b=0x02 -> y=0x02, carry=0.
- Shift and in_ready: SHL a=0x81, n=3 -> in_ready low for 4 cycles, out_valid on the 4th edge, y=0x08, carry=0.
  - SHR a=0x81, n=1 -> y=0x40, carry=1.
  - SHL with n=0 -> y=a, latency 1.
- MUL (ALU_SEQ_MUL_EN defined):
  - 0x0F*0x11 -> y=0xFF, carry=0, out_valid 9 cycles after accept.
  - 0x10*0x10 -> y=0x00, zero=1, carry=1, overflow=1.
  - Macro undefined: 0x0F*0x11 -> y=0x00, zero=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD -> y and flags stable, in_ready=0, new in_valid ignored; state returns to IDLE one cycle after out_ready=1.
- Reset mid-MUL: assert rst during cycle 4 of BUSY -> outputs immediately at reset values. After release, ADC 0x01+0x01 -> y=0x02 (cflag cleared).
